// File: rtl/du_fetch_controller_pkg.sv
`default_nettype none
// du_fetch_controller_pkg: shared widths, opcode and FSM encoding for the distribution-unit fetch path.
// Rev 1.0
package du_fetch_controller_pkg;

  localparam int         DU_ADDR_W   = 32;
  localparam int         DU_DATA_W   = 256;
  localparam int         DU_HDR_BITS = 40;
  localparam logic [7:0] DU_CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_DONE     = 3'd4
  } du_state_t;

  // Chip select is asserted only while the SPI frame is open.
  function automatic logic du_cs_active(input du_state_t s);
    return (s == ST_CS_SETUP) || (s == ST_SHIFT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/du_fetch_controller_if.sv
`default_nettype none
// du_fetch_controller_if: pipeline request/result and SPI pins of the fetch controller.
// Rev 1.0
interface du_fetch_controller_if import du_fetch_controller_pkg::*; #(
  parameter int ADDR_W = DU_ADDR_W,
  parameter int DATA_W = DU_DATA_W
) ();
  logic              du_req;
  logic              du_flush;
  logic [ADDR_W-1:0] rs1;
  logic [DATA_W-1:0] du_result;
  logic              du_result_valid;
  logic              du_clk_stall;
  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;

  modport slave (
    input  du_req, du_flush, rs1, spi_miso,
    output du_result, du_result_valid, du_clk_stall, spi_cs_n, spi_sclk, spi_mosi
  );

  modport master (
    output du_req, du_flush, rs1, spi_miso,
    input  du_result, du_result_valid, du_clk_stall, spi_cs_n, spi_sclk, spi_mosi
  );
endinterface
`default_nettype wire

// File: rtl/du_fetch_controller_spi.sv
`default_nettype none
// du_fetch_controller_spi: mode-0 SPI shifter; sends the command/address header, then captures DATA_W bits.
// Rev 1.0
module du_fetch_controller_spi import du_fetch_controller_pkg::*; #(
  parameter int CLK_DIV  = 2,
  parameter int HDR_BITS = DU_HDR_BITS,
  parameter int DATA_W   = DU_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                run,
  input  logic [HDR_BITS-1:0] tx_data,
  input  logic                miso,
  output logic                sclk,
  output logic                mosi,
  output logic                done,
  output logic [DATA_W-1:0]   rx_data
);
  localparam int XFER_BITS = HDR_BITS + DATA_W;
  localparam int BIT_W     = $clog2(XFER_BITS + 1);
  localparam int DIV_W     = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(XFER_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_HDR  = BIT_W'(HDR_BITS);

  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [HDR_BITS-1:0] tx_shift;
  logic                tick;
  logic                rise;
  logic                fall;

  assign tick = run & (div_cnt == DIV_LAST);
  assign rise = tick & ~sclk;
  assign fall = tick & sclk;
  // Terminates on the final falling edge so the FSM leaves SHIFT on the same clock.
  assign done = fall & (bit_cnt == BIT_LAST);
  // Zeros shift in behind the header, so MOSI idles low once the address is out.
  assign mosi = tx_shift[HDR_BITS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_data  <= '0;
      sclk     <= 1'b0;
    end else if (start) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= tx_data;
      sclk     <= 1'b0;
    end else if (run) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        sclk <= ~sclk;
      end
      if (rise && (bit_cnt >= BIT_HDR)) begin
        rx_data <= {rx_data[DATA_W-2:0], miso};
      end
      if (fall) begin
        bit_cnt  <= bit_cnt + 1'b1;
        tx_shift <= tx_shift << 1;
      end
    end else begin
      sclk <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/du_fetch_controller.sv
`default_nettype none
// du_fetch_controller: stalls the pipeline and fetches a distribution over SPI, with a one-entry address cache.
// Rev 1.0
module du_fetch_controller import du_fetch_controller_pkg::*; #(
  parameter int         CLK_DIV  = 2,
  parameter logic [7:0] CMD_READ = DU_CMD_READ,
  parameter int         ADDR_W   = DU_ADDR_W,
  parameter int         DATA_W   = DU_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  du_fetch_controller_if.slave  bus
);
  localparam int HDR_BITS = 8 + ADDR_W;

  du_state_t         state;
  du_state_t         state_nxt;
  logic              cache_valid;
  logic [ADDR_W-1:0] cache_addr;
  logic [ADDR_W-1:0] req_addr;
  logic              flush_pend;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] rx_data;
  logic              cs_n;
  logic              hit;
  logic              stall;
  logic              start;
  logic              run;
  logic              done;
  logic              sclk;
  logic              mosi;

  assign hit = cache_valid & ~bus.du_flush & (bus.rs1 == cache_addr);

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    start     = 1'b0;
    run       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.du_req) begin
          if (hit) begin
            state_nxt = ST_DONE;
          end else begin
            stall     = 1'b1;
            start     = 1'b1;
            state_nxt = ST_CS_SETUP;
          end
        end
      end
      ST_CS_SETUP: begin
        stall     = 1'b1;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        stall = 1'b1;
        run   = 1'b1;
        if (done) begin
          state_nxt = ST_CS_HOLD;
        end
      end
      ST_CS_HOLD: begin
        stall     = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      req_addr    <= '0;
      flush_pend  <= 1'b0;
      result      <= '0;
      cs_n        <= 1'b1;
    end else begin
      cs_n <= ~du_cs_active(state_nxt);
      // A flush seen while the fetch is in flight keeps that fetch out of the cache.
      if (start) begin
        req_addr   <= bus.rs1;
        flush_pend <= 1'b0;
      end else if (bus.du_flush) begin
        flush_pend <= 1'b1;
      end
      if (state == ST_CS_HOLD) begin
        result      <= rx_data;
        cache_addr  <= req_addr;
        cache_valid <= ~(flush_pend | bus.du_flush);
      end else if (bus.du_flush) begin
        cache_valid <= 1'b0;
      end
    end
  end

  du_fetch_controller_spi #(
    .CLK_DIV  (CLK_DIV),
    .HDR_BITS (HDR_BITS),
    .DATA_W   (DATA_W)
  ) u_spi (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .run     (run),
    .tx_data ({CMD_READ, bus.rs1}),
    .miso    (bus.spi_miso),
    .sclk    (sclk),
    .mosi    (mosi),
    .done    (done),
    .rx_data (rx_data)
  );

  assign bus.du_result       = result;
  assign bus.du_result_valid = (state == ST_DONE);
  assign bus.du_clk_stall    = stall;
  assign bus.spi_cs_n        = cs_n;
  assign bus.spi_sclk        = sclk;
  assign bus.spi_mosi        = mosi;

endmodule
`default_nettype wire
